gpr_mp: RTL and testbench
=========================

# gpr_mp

Parametrised multi-port general-purpose register file for the RV64 core, the successor to the single-write 2-read register file. It is configurable in width, register count, read-port count and write-port count, and keeps x0 hard-wired to zero. Optional write-to-read bypass and a per-register busy scoreboard let the decode/issue stage detect pending producers. It sits between decode (read addresses, reservations) and writeback (write ports).

## Interface
Parameters:
- ARCH_WIDTH, 64, data width of each register
- REG_COUNT, 32, number of architectural registers; power of two, at least 2
- READ_PORTS, 2, number of independent read ports
- WRITE_PORTS, 1, number of independent write ports
- BYPASS, 1, 1 = a same-cycle write is forwarded to reads; 0 = the write is visible from the next cycle
- Derived localparam SEL_WIDTH = $clog2(REG_COUNT)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- rs  in  READ_PORTS*SEL_WIDTH  read addresses; port p uses slice [p*SEL_WIDTH +: SEL_WIDTH]
- out  out  READ_PORTS*ARCH_WIDTH  read data, combinational; port p uses slice [p*ARCH_WIDTH +: ARCH_WIDTH]
- rs_busy  out  READ_PORTS  1 = the register on read port p has a pending producer
- wEn  in  WRITE_PORTS  write enable per write port
- rd  in  WRITE_PORTS*SEL_WIDTH  write addresses
- wData  in  WRITE_PORTS*ARCH_WIDTH  write data
- rsv_en  in  1  reserve strobe: marks rsv_rd busy
- rsv_rd  in  SEL_WIDTH  register to reserve

## Operation
- Storage: REG_COUNT × ARCH_WIDTH flops plus a REG_COUNT-bit busy vector.
- x0 behaviour:
  - register 0 always reads 0;
  - writes to 0 are dropped;
  - busy[0] is never set;
  - rs_busy for address 0 is always 0.
- Writes:
  - For each port w with wEn[w]=1 and rd≠0, reg[rd] takes wData on the clock edge.
  - If several ports target the same rd in one cycle, the highest-index port wins.
- Reads, per port p:
  - BYPASS=1: if any write port writes rs[p] (≠0) this cycle, out[p] is that port's wData, using the highest-index match. Otherwise out[p] = reg[rs[p]].
  - BYPASS=0: out[p] = reg[rs[p]] always.
- Scoreboard:
  - A write to register r clears busy[r] at the clock edge.
  - rsv_en=1 with rsv_rd≠0 sets busy[rsv_rd] at the clock edge.
  - A reserve and a write to the same register in the same cycle leave busy=1: the reservation wins, because it represents a newer producer.
  - rs_busy[p] = busy[rs[p]], except that with BYPASS=1 it reads 0 when a write to rs[p] occurs in the same cycle (the data is being forwarded).
- Reset:
  - While rst=1 at a clock edge, all registers become 0 and all busy bits become 0.
  - Writes and reservations in that cycle are ignored.
  - out and rs_busy remain combinational functions of the state. The bypass path is disabled while rst=1, so out reads stored state only.

## Timing
- Read latency: 0 cycles (combinational from rs and state).
- Write latency:
  - the value is stored at the edge following wEn;
  - it appears on out in the same cycle if BYPASS=1, otherwise from the next cycle.
- Reserve latency: busy visible on rs_busy the cycle after rsv_en.
- Reset:
  - one cycle of rst gives all outputs 0 in the following cycle (out=0, rs_busy=0);
  - reset asserted mid-sequence discards the in-flight write and the reservation from that cycle.
- No handshakes, no stalls: the block is always ready. The caller is responsible for not issuing reads it must not consume while rs_busy=1.

## Test plan
- Reset sanity: pulse rst for 1 cycle, then read all 32 registers on both ports → every out=0 and every rs_busy=0.
- Write and read with BYPASS=1:
  - write x5=0xDEAD_BEEF_0000_0001 with rs[0]=5 in the same cycle → out[0]=0xDEAD_BEEF_0000_0001 that cycle;
  - with BYPASS=0 → the old value 0 that cycle, the new value the next cycle.
- x0 protection: write x0=0xFFFF_FFFF_FFFF_FFFF and reserve x0 → out reads 0 and rs_busy=0 on every subsequent cycle.
- Multi-port conflict (WRITE_PORTS=2): port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle → x7=0x22 next cycle; the bypassed out is also 0x22.
- Scoreboard:
  - reserve x9 → rs_busy=1 for rs=9 next cycle;
  - write x9=0x33 → busy cleared the following cycle (and rs_busy=0 during the write cycle if BYPASS=1);
  - reserve and write x9 in the same cycle → busy stays 1.
- Reset mid-operation: write x3=0x44, then assert rst in the same cycle as a write x4=0x55 and a reserve of x4 → after the edge x3=0, x4=0, busy[4]=0.

Source files
------------

// File: rtl/gpr_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_mp_if
// Description : Decode/writeback-side bus of the multi-port register file:
//               read addresses and data, busy flags, write ports, reservation.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpr_mp_if #(
    parameter int ARCH_WIDTH  = 64,
    parameter int REG_COUNT   = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
);
    localparam int SEL_WIDTH = $clog2(REG_COUNT);

    logic [READ_PORTS*SEL_WIDTH-1:0]   rs;
    logic [READ_PORTS*ARCH_WIDTH-1:0]  out;
    logic [READ_PORTS-1:0]             rs_busy;
    logic [WRITE_PORTS-1:0]            wEn;
    logic [WRITE_PORTS*SEL_WIDTH-1:0]  rd;
    logic [WRITE_PORTS*ARCH_WIDTH-1:0] wData;
    logic                              rsv_en;
    logic [SEL_WIDTH-1:0]              rsv_rd;

    // Pipeline side: drives addresses, writes and reservations
    modport master (
        output rs, wEn, rd, wData, rsv_en, rsv_rd,
        input  out, rs_busy
    );

    // Register file side
    modport slave (
        input  rs, wEn, rd, wData, rsv_en, rsv_rd,
        output out, rs_busy
    );
endinterface
`default_nettype wire

// File: rtl/gpr_mp.sv
`default_nettype none
// ============================================================================
// Module      : gpr_mp
// Description : Parametrised multi-port general-purpose register file with
//               hard-wired x0, optional write-to-read bypass and a per-register
//               busy scoreboard for pending producers.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_mp #(
    parameter int ARCH_WIDTH  = 64,
    parameter int REG_COUNT   = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int BYPASS      = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    gpr_mp_if.slave   bus
);
    localparam int SEL_WIDTH = $clog2(REG_COUNT);

    logic [ARCH_WIDTH-1:0]            regs_q [REG_COUNT];
    logic [ARCH_WIDTH-1:0]            regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]             busy_q;
    logic [REG_COUNT-1:0]             busy_d;
    logic [SEL_WIDTH-1:0]             w_wsel;
    logic [SEL_WIDTH-1:0]             w_rsel;
    logic [READ_PORTS*ARCH_WIDTH-1:0] w_out;
    logic [READ_PORTS-1:0]            w_rs_busy;

    // Next state: ports applied in ascending order so the highest index wins;
    // a reservation is applied after the write clears so the newer producer wins
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        w_wsel = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            w_wsel = bus.rd[w*SEL_WIDTH +: SEL_WIDTH];
            if (bus.wEn[w] && (w_wsel != '0)) begin
                regs_d[w_wsel] = bus.wData[w*ARCH_WIDTH +: ARCH_WIDTH];
                busy_d[w_wsel] = 1'b0;
            end
        end
        if (bus.rsv_en && (bus.rsv_rd != '0)) begin
            busy_d[bus.rsv_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // State register with synchronous reset that also discards that cycle's writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports: stored state, overridden by same-cycle writes when bypassing
    always_comb begin
        w_out     = '0;
        w_rs_busy = '0;
        w_rsel    = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            w_rsel = bus.rs[p*SEL_WIDTH +: SEL_WIDTH];
            if (w_rsel != '0) begin
                w_out[p*ARCH_WIDTH +: ARCH_WIDTH] = regs_q[w_rsel];
                w_rs_busy[p]                      = busy_q[w_rsel];
                if ((BYPASS != 0) && !rst) begin
                    for (int w = 0; w < WRITE_PORTS; w++) begin
                        if (bus.wEn[w] && (bus.rd[w*SEL_WIDTH +: SEL_WIDTH] == w_rsel)) begin
                            w_out[p*ARCH_WIDTH +: ARCH_WIDTH] = bus.wData[w*ARCH_WIDTH +: ARCH_WIDTH];
                            w_rs_busy[p]                      = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.out     = w_out;
    assign bus.rs_busy = w_rs_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpr_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_mp
// Description : Self-checking bench for gpr_mp. Two instances (bypass on and
//               off, two write ports) share one stimulus stream; a reference
//               model of the register file is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_mp;
    localparam int AW = 64;
    localparam int RC = 32;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int SW = 5;

    logic clk;
    logic rst;
    logic [RP*SW-1:0] rs;
    logic [WP-1:0]    wEn;
    logic [WP*SW-1:0] rd;
    logic [WP*AW-1:0] wData;
    logic             rsv_en;
    logic [SW-1:0]    rsv_rd;

    int n_tests;
    int n_fail;
    bit checking;

    // Reference state
    logic [AW-1:0] mem [RC];
    logic [RC-1:0] busy;

    gpr_mp_if #(.ARCH_WIDTH(AW), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP)) ifa ();
    gpr_mp_if #(.ARCH_WIDTH(AW), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP)) ifb ();

    assign ifa.rs = rs;   assign ifb.rs = rs;
    assign ifa.wEn = wEn; assign ifb.wEn = wEn;
    assign ifa.rd = rd;   assign ifb.rd = rd;
    assign ifa.wData = wData;   assign ifb.wData = wData;
    assign ifa.rsv_en = rsv_en; assign ifb.rsv_en = rsv_en;
    assign ifa.rsv_rd = rsv_rd; assign ifb.rsv_rd = rsv_rd;

    gpr_mp #(.ARCH_WIDTH(AW), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .BYPASS(1))
        u_dut_byp (.clk(clk), .rst(rst), .bus(ifa.slave));
    gpr_mp #(.ARCH_WIDTH(AW), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .BYPASS(0))
        u_dut_nobyp (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model update: later assignments win, so the higher port and the reservation take priority
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RC; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            for (int w = 0; w < WP; w++) begin
                if (wEn[w] && rd[w*SW +: SW] != 0) begin
                    mem[rd[w*SW +: SW]]  <= wData[w*AW +: AW];
                    busy[rd[w*SW +: SW]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_rd != 0) busy[rsv_rd] <= 1'b1;
        end
    end

    function automatic logic [AW-1:0] exp_out(input bit byp, input int p);
        logic [SW-1:0] a;
        logic [AW-1:0] v;
        a = rs[p*SW +: SW];
        if (a == 0) return '0;
        v = mem[a];
        if (byp && !rst)
            for (int w = 0; w < WP; w++)
                if (wEn[w] && rd[w*SW +: SW] == a) v = wData[w*AW +: AW];
        return v;
    endfunction

    function automatic logic exp_busy(input bit byp, input int p);
        logic [SW-1:0] a;
        logic b;
        a = rs[p*SW +: SW];
        if (a == 0) return 1'b0;
        b = busy[a];
        if (byp && !rst)
            for (int w = 0; w < WP; w++)
                if (wEn[w] && rd[w*SW +: SW] == a) b = 1'b0;
        return b;
    endfunction

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < RP; p++) begin
                    logic [AW-1:0] got_o;
                    logic          got_b;
                    got_o = (d == 0) ? ifa.out[p*AW +: AW] : ifb.out[p*AW +: AW];
                    got_b = (d == 0) ? ifa.rs_busy[p] : ifb.rs_busy[p];
                    n_tests++;
                    if (got_o !== exp_out(d == 0, p)) begin
                        n_fail++;
                        $display("FAIL model_out dut%0d port%0d t=%0t: got %h expected %h",
                                 d, p, $time, got_o, exp_out(d == 0, p));
                    end
                    n_tests++;
                    if (got_b !== exp_busy(d == 0, p)) begin
                        n_fail++;
                        $display("FAIL model_busy dut%0d port%0d t=%0t: got %b expected %b",
                                 d, p, $time, got_b, exp_busy(d == 0, p));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        wEn = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int port, input logic [SW-1:0] a, input logic [AW-1:0] v);
        wEn[port] = 1'b1;
        rd[port*SW +: SW] = a;
        wData[port*AW +: AW] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        checking = 1'b0;
        rst = 1'b1;
        rs = '0; wEn = '0; rd = '0; wData = '0; rsv_en = 1'b0; rsv_rd = '0;
        #1;
        tick();
        rst = 1'b0;
        checking = 1'b1;

        // Reset sanity: sweep every register on both ports
        for (int r = 0; r < RC; r += 2) begin
            rs = {5'(r + 1), 5'(r)};
            #1;
            chk("reset_out1", ifa.out[AW +: AW], 64'h0);
            tick();
        end

        // Same-cycle bypass versus next-cycle visibility
        wr(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
        rs = {5'd5, 5'd5};
        #1;
        chk("byp_same_cycle", ifa.out[0 +: AW], 64'hDEAD_BEEF_0000_0001);
        chk("nobyp_same_cycle", ifb.out[0 +: AW], 64'h0);
        chk("model_byp", exp_out(1'b1, 0), 64'hDEAD_BEEF_0000_0001);
        tick();
        idle();
        #1;
        chk("nobyp_next_cycle", ifb.out[AW +: AW], 64'hDEAD_BEEF_0000_0001);
        tick();

        // x0 protection
        wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rsv_en = 1'b1; rsv_rd = 5'd0;
        rs = {5'd0, 5'd0};
        #1;
        chk("x0_byp_out", ifa.out[0 +: AW], 64'h0);
        tick();
        idle();
        #1;
        chk("x0_out", ifb.out[0 +: AW], 64'h0);
        chk("x0_busy", {63'h0, ifa.rs_busy[0]}, 64'h0);
        tick();

        // Write-port conflict: highest port wins
        wr(0, 5'd7, 64'h11);
        wr(1, 5'd7, 64'h22);
        rs = {5'd5, 5'd7};
        #1;
        chk("conflict_byp", ifa.out[0 +: AW], 64'h22);
        chk("conflict_nobyp_old", ifb.out[0 +: AW], 64'h0);
        tick();
        idle();
        #1;
        chk("conflict_stored", ifb.out[0 +: AW], 64'h22);
        tick();

        // Scoreboard: reserve, clear by write, reserve+write
        rsv_en = 1'b1; rsv_rd = 5'd9;
        rs = {5'd0, 5'd9};
        tick();
        idle();
        #1;
        chk("rsv_busy", {63'h0, ifb.rs_busy[0]}, 64'h1);
        wr(1, 5'd9, 64'h33);
        #1;
        chk("wr_byp_busy", {63'h0, ifa.rs_busy[0]}, 64'h0);
        chk("wr_nobyp_busy", {63'h0, ifb.rs_busy[0]}, 64'h1);
        tick();
        idle();
        #1;
        chk("cleared_busy", {63'h0, ifb.rs_busy[0]}, 64'h0);
        chk("x9_value", ifb.out[0 +: AW], 64'h33);
        wr(0, 5'd9, 64'h66);
        rsv_en = 1'b1; rsv_rd = 5'd9;
        tick();
        idle();
        #1;
        chk("rsv_wins", {63'h0, ifa.rs_busy[0]}, 64'h1);
        chk("rsv_wins_data", ifa.out[0 +: AW], 64'h66);
        tick();

        // Reset in the middle of traffic
        wr(0, 5'd3, 64'h44);
        tick();
        idle();
        rst = 1'b1;
        wr(0, 5'd4, 64'h55);
        rsv_en = 1'b1; rsv_rd = 5'd4;
        rs = {5'd3, 5'd4};
        #1;
        chk("rst_no_bypass", ifa.out[0 +: AW], 64'h0);
        chk("rst_stored_x3", ifa.out[AW +: AW], 64'h44);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_x3", ifa.out[AW +: AW], 64'h0);
        chk("post_rst_x4", ifa.out[0 +: AW], 64'h0);
        chk("post_rst_busy4", {63'h0, ifa.rs_busy[0]}, 64'h0);
        tick();

        // Fill every register alternating write ports; reserve some already-written ones
        for (int r = 1; r < RC; r++) begin
            idle();
            wr(r & 1, 5'(r), {32'(r), 32'hA5A5_0000 ^ 32'(r)});
            if (r % 3 == 0) begin
                rsv_en = 1'b1;
                rsv_rd = 5'(r - 1);
            end
            rs = {5'(r - 1), 5'(r)};
            tick();
        end
        idle();
        for (int r = 0; r < RC; r++) begin
            rs = {5'(RC - 1 - r), 5'(r)};
            tick();
        end
        rs = {5'd6, 5'd5};
        #1;
        chk("fill_x6", ifb.out[AW +: AW], {32'd6, 32'hA5A5_0006});
        chk("fill_busy_x5", {63'h0, ifa.rs_busy[0]}, 64'h1);
        chk("fill_busy_x6", {63'h0, ifa.rs_busy[1]}, 64'h0);
        tick();
        tick();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
